// File: rtl/sign_flow_ctrl_pkg.sv
// Shared definitions for the Picnic-on-SM4 signing sequencer (package sign_pkg).
// Holds the scheme sizes, the lc/lp packing width, the FSM state encoding
// and the watchdog limit used when SIGN_FLOW_TIMEOUT_EN is defined.
package sign_pkg;

    // Scheme sizes
    localparam int M       = 8;     // MPC instances, lc values in 0..M-1
    localparam int TAU     = 4;     // opened instances (entries in lc and lp)
    localparam int N       = 16;    // parties per instance, lp values in 0..N-1

    // Per-stage watchdog limit in cycles (only meaningful with the timeout build)
    localparam int TMO_CYC = 4096;
    localparam int TW      = 13;    // watchdog counter width, holds TMO_CYC

    // Digest and challenge packing
    localparam int HW      = 256;           // H1 digest width
    localparam int LW      = 5;             // bits per packed lc/lp entry
    localparam int LCW     = TAU * LW;      // packed lc/lp width
    localparam int CW      = $clog2(M);     // candidate chunk width (phase A)
    localparam int PW      = $clog2(N);     // party nibble width (phase B)
    localparam int IW      = $clog2(TAU);   // slot index width
    localparam int LFW     = $clog2(HW + 1); // remaining-bit counter width

    // Sequencer states; the encoding is exported on the stage debug port
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEED   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_H1     = 3'd3,
        ST_CHAL   = 3'd4,
        ST_PACK   = 3'd5,
        ST_FIN    = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // A run is in progress in every state except the idle and terminal ones
    function automatic logic is_busy(input state_t s);
        return !(s inside {ST_IDLE, ST_FIN, ST_ERR});
    endfunction

endpackage

// File: rtl/sign_flow_ctrl_if.sv
// Engine-side bus of the signing sequencer: the four start/end handshakes,
// the H1 digest and the expanded challenge lists consumed by the packer.
// master = sequencer side, slave = engine side.
interface sign_flow_ctrl_if;
    import sign_pkg::*;

    logic           seed_start;
    logic           seed_end;
    logic           commit_start;
    logic           commit_end;
    logic           h1_start;
    logic           h1_end;
    logic [HW-1:0]  h_t;
    logic           pack_start;
    logic           pack_end;
    logic [LCW-1:0] lc;
    logic [LCW-1:0] lp;

    modport master (
        output seed_start, commit_start, h1_start, pack_start, lc, lp,
        input  seed_end, commit_end, h1_end, h_t, pack_end
    );

    modport slave (
        input  seed_start, commit_start, h1_start, pack_start, lc, lp,
        output seed_end, commit_end, h1_end, h_t, pack_end
    );

endinterface

// File: rtl/sign_flow_ctrl_chal_expand.sv
// Challenge expansion: turns the captured H1 digest into the opened-instance
// list lc and the hidden-party list lp, one chunk per cycle, MSB first.
// Phase A draws CW-bit candidates and keeps only values not yet accepted;
// phase B draws one PW-bit party index per accepted slot.
// chal_end is combinational and marks the cycle the last chunk is consumed,
// so the time spent in CHAL equals the number of chunks consumed.
module chal_expand
    import sign_pkg::*;
(
    input  logic           clk,
    input  logic           reset,       // asynchronous, active-low
    input  logic           load,        // capture h_t and restart the expansion
    input  logic [HW-1:0]  h_t,
    input  logic           chal_start,  // level: consume one chunk per cycle
    output logic           chal_end,    // last chunk consumed this cycle
    output logic           exhausted,   // digest ran out before completion
    output logic [LCW-1:0] lc,
    output logic [LCW-1:0] lp
);

    typedef enum logic {PH_INST, PH_PARTY} phase_t;

    logic [HW-1:0]  sh_reg;
    logic [LFW-1:0] left_reg;
    logic [IW-1:0]  idx_reg;
    phase_t         phase_reg;
    logic [LW-1:0]  lc_reg [TAU];
    logic [LW-1:0]  lp_reg [TAU];

    logic [CW-1:0]  cand;
    logic [PW-1:0]  nib;
    logic [TAU-1:0] hit_vec;
    logic           dup;
    logic           short_bits;
    logic           consume;
    logic           last_slot;

    assign cand = sh_reg[HW-1 -: CW];
    assign nib  = sh_reg[HW-1 -: PW];

    // Per-slot duplicate compare (only slots already accepted count) and output packing,
    // entry 0 placed at the MSBs
    genvar gi;
    generate
        for (gi = 0; gi < TAU; gi++) begin : g_slot
            assign hit_vec[gi] = (IW'(gi) < idx_reg) && (lc_reg[gi] == LW'(cand));
            assign lc[(TAU-1-gi)*LW +: LW] = lc_reg[gi];
            assign lp[(TAU-1-gi)*LW +: LW] = lp_reg[gi];
        end
    endgenerate

    assign dup        = |hit_vec;
    assign last_slot  = (idx_reg == IW'(TAU - 1));
    assign short_bits = (phase_reg == PH_INST) ? (left_reg < LFW'(CW)) : (left_reg < LFW'(PW));
    assign consume    = chal_start && !short_bits;
    assign exhausted  = chal_start && short_bits;
    assign chal_end   = consume && (phase_reg == PH_PARTY) && last_slot;

    // Shift register, slot counters and list registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_reg    <= '0;
            left_reg  <= '0;
            idx_reg   <= '0;
            phase_reg <= PH_INST;
            for (int i = 0; i < TAU; i++) begin
                lc_reg[i] <= '0;
                lp_reg[i] <= '0;
            end
        end else if (load) begin
            sh_reg    <= h_t;
            left_reg  <= LFW'(HW);
            idx_reg   <= '0;
            phase_reg <= PH_INST;
            for (int i = 0; i < TAU; i++) begin
                lc_reg[i] <= '0;
                lp_reg[i] <= '0;
            end
        end else if (consume) begin
            if (phase_reg == PH_INST) begin
                sh_reg   <= sh_reg << CW;
                left_reg <= left_reg - LFW'(CW);
                if (!dup) begin
                    lc_reg[idx_reg] <= LW'(cand);
                    if (last_slot) begin
                        idx_reg   <= '0;
                        phase_reg <= PH_PARTY;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
            end else begin
                sh_reg          <= sh_reg << PW;
                left_reg        <= left_reg - LFW'(PW);
                lp_reg[idx_reg] <= LW'(nib);
                if (!last_slot) begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sign_flow_ctrl.sv
// Top-level sequencer for one Picnic-on-SM4 signing run.
// Walks SEED -> COMMIT -> H1 -> CHAL -> PACK with one engine start active at
// a time, expands the H1 digest via chal_expand, and reports done/err to the host.
// Optional per-stage watchdog: define SIGN_FLOW_TIMEOUT_EN.
module sign_flow_ctrl
    import sign_pkg::*;
(
    input  logic             clk,
    input  logic             reset,       // asynchronous, active-low
    input  logic             sign_start,
    output logic             sign_done,
    output logic             sign_err,
    output logic             busy,
    output logic [2:0]       stage,
    sign_flow_ctrl_if.master eng
);

    state_t state_reg, state_next;
    logic   done_reg, done_next;
    logic   err_reg, err_next;
    logic   seed_start_reg, seed_start_next;
    logic   commit_start_reg, commit_start_next;
    logic   h1_start_reg, h1_start_next;
    logic   pack_start_reg, pack_start_next;
    logic   load_h;
    logic   chal_start;
    logic   chal_end;
    logic   chal_exh;
    logic   tmo_hit;

`ifdef SIGN_FLOW_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt_reg;
    logic          waiting;

    assign waiting = state_reg inside {ST_SEED, ST_COMMIT, ST_H1, ST_PACK};
    // Fires in the cycle whose edge would bring the count to TMO_CYC
    assign tmo_hit = waiting && (tmo_cnt_reg == TW'(TMO_CYC - 1));

    // Stage watchdog: restarts on every state change, counts while waiting on an engine
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            tmo_cnt_reg <= '0;
        end else if (waiting) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign chal_start = (state_reg == ST_CHAL);

    chal_expand u_chal (
        .clk        (clk),
        .reset      (reset),
        .load       (load_h),
        .h_t        (eng.h_t),
        .chal_start (chal_start),
        .chal_end   (chal_end),
        .exhausted  (chal_exh),
        .lc         (eng.lc),
        .lp         (eng.lp)
    );

    // Next-state and next-output logic; a falling sign_start aborts any active stage
    always_comb begin
        state_next = state_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        load_h     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // seed_end still high means the engine has not released the last handshake
                if (sign_start && !done_reg && !err_reg && !eng.seed_end) begin
                    state_next = ST_SEED;
                end
            end
            ST_SEED: begin
                if (!sign_start) begin
                    state_next = ST_IDLE;
                end else if (eng.seed_end) begin
                    state_next = ST_COMMIT;
                end else if (tmo_hit) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
            end
            ST_COMMIT: begin
                if (!sign_start) begin
                    state_next = ST_IDLE;
                end else if (eng.commit_end) begin
                    state_next = ST_H1;
                end else if (tmo_hit) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
            end
            ST_H1: begin
                if (!sign_start) begin
                    state_next = ST_IDLE;
                end else if (eng.h1_end) begin
                    state_next = ST_CHAL;
                    load_h     = 1'b1;
                end else if (tmo_hit) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
            end
            ST_CHAL: begin
                if (!sign_start) begin
                    state_next = ST_IDLE;
                end else if (chal_exh) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end else if (chal_end) begin
                    state_next = ST_PACK;
                end
            end
            ST_PACK: begin
                if (!sign_start) begin
                    state_next = ST_IDLE;
                end else if (eng.pack_end) begin
                    state_next = ST_FIN;
                    done_next  = 1'b1;
                end else if (tmo_hit) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
            end
            ST_FIN: begin
                if (!sign_start) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b0;
                end
            end
            ST_ERR: begin
                if (!sign_start) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Each start follows its stage, so at most one is ever high
        seed_start_next   = (state_next == ST_SEED);
        commit_start_next = (state_next == ST_COMMIT);
        h1_start_next     = (state_next == ST_H1);
        pack_start_next   = (state_next == ST_PACK);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            seed_start_reg   <= 1'b0;
            commit_start_reg <= 1'b0;
            h1_start_reg     <= 1'b0;
            pack_start_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            done_reg         <= done_next;
            err_reg          <= err_next;
            seed_start_reg   <= seed_start_next;
            commit_start_reg <= commit_start_next;
            h1_start_reg     <= h1_start_next;
            pack_start_reg   <= pack_start_next;
        end
    end

    assign eng.seed_start   = seed_start_reg;
    assign eng.commit_start = commit_start_reg;
    assign eng.h1_start     = h1_start_reg;
    assign eng.pack_start   = pack_start_reg;

    assign sign_done = done_reg;
    assign sign_err  = err_reg;
    assign busy      = is_busy(state_reg);
    assign stage     = state_reg;

endmodule
